// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe
//   Registered RV32I decode stage between fetch and execute.
//
//   The stage reads two register-file ports combinationally and builds the
//   operand pair and the sign-extended immediate for each base opcode class.
//   Unsupported encodings are flagged as illegal. The result is held in a
//   pipeline register with a valid/ready handshake, and that register
//   survives downstream stalls and pipeline flushes.
//
//   Optional feature macro: DECODE_BYPASS_EN
//     defined   - A writeback that targets a source register is forwarded into
//                 the operand at capture time. A held (stalled) register
//                 operand is also refreshed when its register is written.
//     undefined - Operands come only from rs*_data. The register file must
//                 provide write-before-read.
//
//   Parameters
//     XLEN       datapath width; immediates are sign-extended to XLEN
//     RF_ADDR_W  register index width (4 selects the RV32E register file)
//
//   Ports
//     clk, rst                 clock; asynchronous active-high reset
//     in_valid/in_ready        fetch-side handshake
//     in_ir, in_pc             instruction word and its address
//     flush                    kills the held and the incoming instruction
//     rs1_addr, rs2_addr       combinational register-file read indices
//     rs1_data, rs2_data       register-file read data (same cycle)
//     wb_en/wb_addr/wb_data    register-file writeback port
//     out_valid/out_ready      execute-side handshake
//     out_op1, out_op2         operand pair
//     out_imm                  sign-extended immediate
//     out_pc, out_rd           captured pc and destination register
//     out_opcode/funct3/funct7 raw instruction fields
//     out_illegal              encoding unsupported (operands forced to 0)
module instr_decode_pipe #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ir,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic [RF_ADDR_W-1:0] rs1_addr,
  output logic [RF_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_en,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic                 out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Each immediate is first assembled as a 32-bit value. It is then
  // sign-extended to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic                 accept;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [XLEN-1:0]      imm_i, imm_s, imm_b, imm_u, imm_j, shamt_zx;
  logic [XLEN-1:0]      rs1_val, rs2_val;
  logic [XLEN-1:0]      dec_op1, dec_op2, dec_imm;
  logic                 dec_op1_rf, dec_op2_rf, dec_illegal;
  logic                 known, uses_rs1, uses_rs2, uses_rd, rv32e_bad;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign rs1_addr = in_ir[15 +: RF_ADDR_W];
  assign rs2_addr = in_ir[20 +: RF_ADDR_W];
  assign opcode   = in_ir[6:0];
  assign funct3   = in_ir[14:12];

  assign imm_i    = sext32({{20{in_ir[31]}}, in_ir[31:20]});
  assign imm_s    = sext32({{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]});
  assign imm_b    = sext32({{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25],
                            in_ir[11:8], 1'b0});
  assign imm_u    = sext32({in_ir[31:12], 12'b0});
  assign imm_j    = sext32({{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20],
                            in_ir[30:21], 1'b0});
  assign shamt_zx = XLEN'(in_ir[24:20]);

`ifdef DECODE_BYPASS_EN
  logic wb_hit1, wb_hit2;
  assign wb_hit1 = wb_en && (wb_addr != '0) && (wb_addr == rs1_addr);
  assign wb_hit2 = wb_en && (wb_addr != '0) && (wb_addr == rs2_addr);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data, dec_op1_rf, dec_op2_rf};
`endif

  // Register read values. Register x0 always reads as zero. This check comes
  // last, so a writeback aimed at x0 can never leak into an operand.
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
`ifdef DECODE_BYPASS_EN
    if (wb_hit1) rs1_val = wb_data;
    if (wb_hit2) rs2_val = wb_data;
`endif
    if (rs1_addr == '0) rs1_val = '0;
    if (rs2_addr == '0) rs2_val = '0;
  end

  // Operand selection per opcode class. The *_rf flags mark operands that
  // came from the register file. Only those operands may be refreshed by a
  // writeback while the stage is stalled.
  always_comb begin
    dec_op1    = '0;
    dec_op2    = '0;
    dec_imm    = '0;
    dec_op1_rf = 1'b0;
    dec_op2_rf = 1'b0;
    known      = 1'b1;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    uses_rd    = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op1 = rs1_val;  dec_op2 = rs2_val;
        dec_op1_rf = 1'b1;  dec_op2_rf = 1'b1;
        uses_rs1 = 1'b1;    uses_rs2 = 1'b1;  uses_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_op1 = rs1_val;
        dec_op2 = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_zx : imm_i;
        dec_imm = imm_i;
        dec_op1_rf = 1'b1;  uses_rs1 = 1'b1;  uses_rd = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        dec_op1 = rs1_val;  dec_op2 = imm_i;  dec_imm = imm_i;
        dec_op1_rf = 1'b1;  uses_rs1 = 1'b1;  uses_rd = 1'b1;
      end
      OPC_STORE: begin
        dec_op1 = rs1_val;  dec_op2 = rs2_val;  dec_imm = imm_s;
        dec_op1_rf = 1'b1;  dec_op2_rf = 1'b1;
        uses_rs1 = 1'b1;    uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_op1 = rs1_val;  dec_op2 = rs2_val;  dec_imm = imm_b;
        dec_op1_rf = 1'b1;  dec_op2_rf = 1'b1;
        uses_rs1 = 1'b1;    uses_rs2 = 1'b1;
      end
      OPC_LUI: begin
        dec_op2 = imm_u;  dec_imm = imm_u;  uses_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op1 = in_pc;  dec_op2 = imm_u;  dec_imm = imm_u;  uses_rd = 1'b1;
      end
      OPC_JAL: begin
        dec_op1 = in_pc;  dec_op2 = imm_j;  dec_imm = imm_j;  uses_rd = 1'b1;
      end
      default: known = 1'b0;
    endcase

    // RV32E has only 16 registers. The bit-4 check applies only to fields
    // that this format uses as register indices, so immediate bits that
    // share those positions are not flagged.
    rv32e_bad = 1'b0;
    if (RF_ADDR_W == 4)
      rv32e_bad = (uses_rs1 && in_ir[19]) || (uses_rs2 && in_ir[24]) ||
                  (uses_rd && in_ir[11]);

    dec_illegal = !known || (in_ir == 32'b0) || (in_ir[1:0] != 2'b11) || rv32e_bad;
    if (dec_illegal) begin
      dec_op1    = '0;
      dec_op2    = '0;
      dec_imm    = '0;
      dec_op1_rf = 1'b0;
      dec_op2_rf = 1'b0;
    end
  end

`ifdef DECODE_BYPASS_EN
  logic [RF_ADDR_W-1:0] held_rs1, held_rs2;
  logic                 held_op1_rf, held_op2_rf;
`endif

  // Pipeline register. Flush wins over accept.
  // A consume with no new accept empties the stage.
  // A stall holds the register, apart from the writeback refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rd      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_illegal <= 1'b0;
`ifdef DECODE_BYPASS_EN
      held_rs1    <= '0;
      held_rs2    <= '0;
      held_op1_rf <= 1'b0;
      held_op2_rf <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op1     <= dec_op1;
      out_op2     <= dec_op2;
      out_imm     <= dec_imm;
      out_pc      <= in_pc;
      out_rd      <= in_ir[7 +: RF_ADDR_W];
      out_opcode  <= in_ir[6:0];
      out_funct3  <= in_ir[14:12];
      out_funct7  <= in_ir[31:25];
      out_illegal <= dec_illegal;
`ifdef DECODE_BYPASS_EN
      held_rs1    <= rs1_addr;
      held_rs2    <= rs2_addr;
      held_op1_rf <= dec_op1_rf;
      held_op2_rf <= dec_op2_rf;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
`ifdef DECODE_BYPASS_EN
    else if (out_valid && wb_en && (wb_addr != '0)) begin
      if (held_op1_rf && (wb_addr == held_rs1)) out_op1 <= wb_data;
      if (held_op2_rf && (wb_addr == held_rs2)) out_op2 <= wb_data;
    end
`endif
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe
//   Self-checking bench for instr_decode_pipe.
//   The main instance uses RF_ADDR_W=5. A second instance uses RF_ADDR_W=4
//   and shares the same stimulus; only its illegal flag is examined.
//   The bench first applies a table of hand-decoded vectors. Next come
//   hand-written stall, flush, bypass and reset sequences. Last is a
//   randomized run, checked against a behavioural decode model.
//   The bench follows DECODE_BYPASS_EN the same way the design does.
`timescale 1ns/1ps
module tb_instr_decode_pipe;

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, flush, wb_en;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] in_ir, in_pc, rs1_data, rs2_data, wb_data;
  logic [31:0] out_op1, out_op2, out_imm, out_pc;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  logic        e_out_illegal, unused_e_ready, unused_e_valid;
  logic [3:0]  unused_e_rs1, unused_e_rs2, unused_e_rd;
  logic [31:0] unused_e_op1, unused_e_op2, unused_e_imm, unused_e_pc;
  logic [6:0]  unused_e_opc, unused_e_f7;
  logic [2:0]  unused_e_f3;

  int n_cmp = 0;
  int n_bad = 0;

  instr_decode_pipe #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_illegal(out_illegal)
  );

  instr_decode_pipe #(.XLEN(32), .RF_ADDR_W(4)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_e_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush),
    .rs1_addr(unused_e_rs1), .rs2_addr(unused_e_rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr[3:0]), .wb_data(wb_data),
    .out_valid(unused_e_valid), .out_ready(out_ready),
    .out_op1(unused_e_op1), .out_op2(unused_e_op2), .out_imm(unused_e_imm),
    .out_pc(unused_e_pc), .out_rd(unused_e_rd), .out_opcode(unused_e_opc),
    .out_funct3(unused_e_f3), .out_funct7(unused_e_f7),
    .out_illegal(e_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected contents of the decode stage
  typedef struct {
    logic        valid;
    logic [31:0] op1, op2, imm, pc;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        illegal, op1_rf, op2_rf;
  } exp_t;

  typedef struct {
    logic [31:0] ir, pc, r1, r2, op1, op2, imm;
    logic [4:0]  rd;
    logic        ill, ill_e;
  } vec_t;

  exp_t m;
  vec_t vecs[18];

  function automatic logic [31:0] readReg(input logic [4:0] idx, input logic [31:0] data);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && wb_en && wb_addr == idx) return wb_data;
    return data;
  endfunction

  // Behavioural decode: the immediates are derived from one another with
  // masks, not assembled field by field.
  function automatic exp_t modelDecode(input logic [31:0] ir, pc, r1, r2);
    exp_t e;
    logic [31:0] iI, iS, iB, iU, iJ, a, b;
    e = '{default: '0};
    e.valid = 1'b1;  e.pc = pc;  e.rd = ir[11:7];  e.rs1 = ir[19:15];
    e.rs2 = ir[24:20];  e.opcode = ir[6:0];  e.funct3 = ir[14:12];
    e.funct7 = ir[31:25];
    iI = 32'($signed(ir) >>> 20);
    iS = {iI[31:5], ir[11:7]};
    iB = (iS & ~32'h801) | (32'(ir[7]) << 11);
    iU = ir & 32'hFFFFF000;
    iJ = (iI & 32'hFFF007FE) | (ir & 32'h000FF000) | (32'(ir[20]) << 11);
    a = readReg(ir[19:15], r1);
    b = readReg(ir[24:20], r2);
    case (ir[6:0])
      7'h33: begin e.op1 = a; e.op2 = b; e.op1_rf = 1; e.op2_rf = 1; end
      7'h13: begin
        e.op1 = a; e.imm = iI; e.op1_rf = 1;
        e.op2 = (ir[14:12] == 3'd1 || ir[14:12] == 3'd5) ? {27'd0, ir[24:20]} : iI;
      end
      7'h03, 7'h67: begin e.op1 = a; e.op2 = iI; e.imm = iI; e.op1_rf = 1; end
      7'h23: begin e.op1 = a; e.op2 = b; e.imm = iS; e.op1_rf = 1; e.op2_rf = 1; end
      7'h63: begin e.op1 = a; e.op2 = b; e.imm = iB; e.op1_rf = 1; e.op2_rf = 1; end
      7'h37: begin e.op2 = iU; e.imm = iU; end
      7'h17: begin e.op1 = pc; e.op2 = iU; e.imm = iU; end
      7'h6F: begin e.op1 = pc; e.op2 = iJ; e.imm = iJ; end
      default: e.illegal = 1'b1;
    endcase
    if (ir == 32'd0 || ir[1:0] != 2'b11) e.illegal = 1'b1;
    if (e.illegal) begin
      e.op1 = 0; e.op2 = 0; e.imm = 0; e.op1_rf = 0; e.op2_rf = 0;
    end
    return e;
  endfunction

  // Advance the model by one clock edge, using the inputs now applied
  task automatic modelStep();
    logic rdy;
    rdy = !m.valid || out_ready;
    if (flush) m.valid = 1'b0;
    else if (in_valid && rdy) m = modelDecode(in_ir, in_pc, rs1_data, rs2_data);
    else if (out_ready) m.valid = 1'b0;
    else if (BYPASS && m.valid && wb_en && wb_addr != 5'd0) begin
      if (m.op1_rf && wb_addr == m.rs1) m.op1 = wb_data;
      if (m.op2_rf && wb_addr == m.rs2) m.op2 = wb_data;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid",   32'(out_valid),   32'(m.valid));
    checkVal("out_op1",     out_op1,          m.op1);
    checkVal("out_op2",     out_op2,          m.op2);
    checkVal("out_imm",     out_imm,          m.imm);
    checkVal("out_pc",      out_pc,           m.pc);
    checkVal("out_rd",      32'(out_rd),      32'(m.rd));
    checkVal("out_opcode",  32'(out_opcode),  32'(m.opcode));
    checkVal("out_funct3",  32'(out_funct3),  32'(m.funct3));
    checkVal("out_funct7",  32'(out_funct7),  32'(m.funct7));
    checkVal("out_illegal", 32'(out_illegal), 32'(m.illegal));
  endtask

  task automatic applyStimulus(input logic [31:0] ir, pc, r1, r2, input logic iv, ordy, fl,
                               input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    in_ir = ir;  in_pc = pc;  rs1_data = r1;  rs2_data = r2;
    in_valid = iv;  out_ready = ordy;  flush = fl;
    wb_en = wen;  wb_addr = wa;  wb_data = wd;
  endtask

  // Called one time unit after a rising edge, with the inputs already applied
  task automatic stepCycle();
    #1;
    checkVal("in_ready", 32'(in_ready), 32'(!m.valid || out_ready));
    checkVal("rs1_addr", 32'(rs1_addr), 32'(in_ir[19:15]));
    checkVal("rs2_addr", 32'(rs2_addr), 32'(in_ir[24:20]));
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic logic [6:0] pickOpcode(input int k);
    case (k)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;
      3: return 7'h23;  4: return 7'h63;  5: return 7'h37;
      6: return 7'h17;  7: return 7'h6F;  default: return 7'h67;
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ir, pc, rs1_data, rs2_data, op1, op2, imm, rd, illegal, illegal(RV32E)
    vecs[0]  = '{32'hFFB10093, 32'h0,    32'd10,       32'h999,  32'd10,       32'hFFFFFFFB, 32'hFFFFFFFB, 5'd1,  1'b0, 1'b0};
    vecs[1]  = '{32'hFE208CE3, 32'h100,  32'h1234,     32'hABCD, 32'h1234,     32'hABCD,     32'hFFFFFFF8, 5'd25, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000000, 32'h4,    32'd5,        32'd6,    32'd0,        32'd0,        32'd0,        5'd0,  1'b1, 1'b1};
    vecs[3]  = '{32'h0000007F, 32'h8,    32'd5,        32'd6,    32'd0,        32'd0,        32'd0,        5'd0,  1'b1, 1'b1};
    vecs[4]  = '{32'h123452B7, 32'hC,    32'd7,        32'd8,    32'd0,        32'h12345000, 32'h12345000, 5'd5,  1'b0, 1'b0};
    vecs[5]  = '{32'hFFFFF297, 32'h2000, 32'd7,        32'd8,    32'h2000,     32'hFFFFF000, 32'hFFFFF000, 5'd5,  1'b0, 1'b0};
    vecs[6]  = '{32'hFFDFF0EF, 32'h300,  32'd7,        32'd8,    32'h300,      32'hFFFFFFFC, 32'hFFFFFFFC, 5'd1,  1'b0, 1'b0};
    vecs[7]  = '{32'h00721193, 32'h10,   32'hF0,       32'd8,    32'hF0,       32'd7,        32'd7,        5'd3,  1'b0, 1'b0};
    vecs[8]  = '{32'h40325193, 32'h14,   32'h80000000, 32'd8,    32'h80000000, 32'd3,        32'h403,      5'd3,  1'b0, 1'b0};
    vecs[9]  = '{32'hFE20AE23, 32'h18,   32'h1000,     32'hCAFE, 32'h1000,     32'hCAFE,     32'hFFFFFFFC, 5'd28, 1'b0, 1'b0};
    vecs[10] = '{32'h00802283, 32'h1C,   32'hDEAD,     32'd8,    32'd0,        32'd8,        32'd8,        5'd5,  1'b0, 1'b0};
    vecs[11] = '{32'h004300E7, 32'h20,   32'h4000,     32'd8,    32'h4000,     32'd4,        32'd4,        5'd1,  1'b0, 1'b0};
    vecs[12] = '{32'h002081B3, 32'h24,   32'h11,       32'h22,   32'h11,       32'h22,       32'd0,        5'd3,  1'b0, 1'b0};
    vecs[13] = '{32'h00100813, 32'h28,   32'h99,       32'd8,    32'd0,        32'd1,        32'd1,        5'd16, 1'b0, 1'b1};
    vecs[14] = '{32'h010100B3, 32'h2C,   32'd3,        32'd4,    32'd3,        32'd4,        32'd0,        5'd1,  1'b0, 1'b1};
    vecs[15] = '{32'h00000001, 32'h30,   32'd3,        32'd4,    32'd0,        32'd0,        32'd0,        5'd0,  1'b1, 1'b1};
    vecs[16] = '{32'h00000073, 32'h34,   32'd3,        32'd4,    32'd0,        32'd0,        32'd0,        5'd0,  1'b1, 1'b1};
    vecs[17] = '{32'hFFB10093, 32'h38,   32'd10,       32'h999,  32'd10,       32'hFFFFFFFB, 32'hFFFFFFFB, 5'd1,  1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m = '{default: '0};
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput();
    checkVal("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Table of hand-decoded vectors, back to back at full throughput
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].ir, vecs[i].pc, vecs[i].r1, vecs[i].r2, 1, 1, 0, 0, 0, 0);
      stepCycle();
      checkVal($sformatf("vec%0d_valid", i),   32'(out_valid),     32'd1);
      checkVal($sformatf("vec%0d_op1", i),     out_op1,            vecs[i].op1);
      checkVal($sformatf("vec%0d_op2", i),     out_op2,            vecs[i].op2);
      checkVal($sformatf("vec%0d_imm", i),     out_imm,            vecs[i].imm);
      checkVal($sformatf("vec%0d_pc", i),      out_pc,             vecs[i].pc);
      checkVal($sformatf("vec%0d_rd", i),      32'(out_rd),        32'(vecs[i].rd));
      checkVal($sformatf("vec%0d_illegal", i), 32'(out_illegal),   32'(vecs[i].ill));
      checkVal($sformatf("vec%0d_ill_e", i),   32'(e_out_illegal), 32'(vecs[i].ill_e));
    end

    // Stall for three cycles while fetch keeps offering a new instruction
    applyStimulus(32'h002081B3, 32'h500, 32'h11, 32'h22, 1, 1, 0, 0, 0, 0);
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'hFFB10093, 32'h504, 32'h33, 32'h44, 1, 0, 0, 0, 0, 0);
      stepCycle();
      checkVal("stall_in_ready", 32'(in_ready), 32'd0);
      checkVal("stall_pc", out_pc, 32'h500);
      checkVal("stall_op1", out_op1, 32'h11);
    end
    applyStimulus(32'hFFB10093, 32'h504, 32'h33, 32'h44, 1, 1, 0, 0, 0, 0);
    stepCycle();
    checkVal("release_pc", out_pc, 32'h504);
    checkVal("release_op1", out_op1, 32'h33);

    // Flush while stalled, with an instruction offered at the same time
    applyStimulus(32'h002081B3, 32'h600, 32'h1, 32'h2, 1, 0, 1, 0, 0, 0);
    stepCycle();
    checkVal("flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    stepCycle();
    checkVal("flush_dropped_valid", 32'(out_valid), 32'd0);
    checkVal("flush_dropped_pc", out_pc, 32'h504);

    // Flush takes priority over an accept that would otherwise happen
    applyStimulus(32'h002081B3, 32'h700, 32'h1, 32'h2, 1, 1, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(32'hFFB10093, 32'h704, 32'h1, 32'h2, 1, 1, 1, 0, 0, 0);
    stepCycle();
    checkVal("flush_prio_valid", 32'(out_valid), 32'd0);
    checkVal("flush_prio_pc", out_pc, 32'h700);

    // Writeback forwarding at capture, then a refresh while stalled
    applyStimulus(32'h002081B3, 32'h800, 32'h0, 32'h22, 1, 1, 0, 1, 5'd1, 32'h55);
    stepCycle();
    checkVal("bypass_capture_op1", out_op1, BYPASS ? 32'h55 : 32'h0);
    checkVal("bypass_capture_op2", out_op2, 32'h22);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'h77);
    stepCycle();
    checkVal("stall_refresh_op2", out_op2, BYPASS ? 32'h77 : 32'h22);
    checkVal("stall_refresh_op1", out_op1, BYPASS ? 32'h55 : 32'h0);

    // An immediate operand is never refreshed (JALR x1,4(x6); rs2 field = 4)
    applyStimulus(32'h004300E7, 32'h900, 32'h4000, 32'h0, 1, 1, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h99);
    stepCycle();
    checkVal("imm_not_refreshed", out_op2, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 32'hABC);
    stepCycle();
    checkVal("jalr_rs1_refresh", out_op1, BYPASS ? 32'hABC : 32'h4000);

    // Asynchronous reset in the middle of a stall drops the held instruction
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    m = '{default: '0};
    checkVal("async_reset_valid", 32'(out_valid), 32'd0);
    checkVal("async_reset_op1", out_op1, 32'd0);
    checkVal("async_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic checked against the model
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ir;
      logic [4:0]  wa;
      ir = $urandom;
      if ($urandom_range(0, 9) < 8) ir[6:0] = pickOpcode($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) ir[19:15] = 5'd0;
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) wa = m.rs1;
      else if ($urandom_range(0, 2) == 0) wa = m.rs2;
      applyStimulus(ir, $urandom, $urandom, $urandom,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                    wa, $urandom);
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Registered RV32I decode stage with a valid/ready handshake, sitting between fetch and execute. It reads two register-file ports combinationally, builds the operand pair and sign-extended immediate for every base opcode class, and flags illegal encodings. Results are held in a pipeline register that tolerates downstream stalls and pipeline flushes. Operands are kept coherent with register-file writebacks, both at capture time and while stalled.

## Interface
- XLEN, 32: datapath width; immediates are sign-extended to XLEN.
- RF_ADDR_W, 5: register index width; 4 selects the RV32E register file.

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_ir  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  kill the held and incoming instruction
- rs1_addr, rs2_addr  out  RF_ADDR_W  combinational read addresses, taken from in_ir[19:15] and in_ir[24:20]
- rs1_data, rs2_data  in  XLEN  register-file read data, same cycle
- wb_en, wb_addr, wb_data  in  1 / RF_ADDR_W / XLEN  writeback port
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute consumes
- out_op1, out_op2, out_imm  out  XLEN  operands and immediate
- out_pc  out  XLEN  captured in_pc
- out_rd  out  RF_ADDR_W  destination register
- out_opcode, out_funct3, out_funct7  out  7/3/7  raw instruction fields
- out_illegal  out  1  encoding unsupported

## Operation
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready && !flush.
  - On accept, every output field is captured and out_valid becomes 1.
  - A consume without a new accept clears out_valid.
- Flush clears out_valid at the next edge and drops any instruction presented in the same cycle. Flush has priority over accept.
- Immediate formats; all take the sign from ir[31]:
  - I: ir[31:20]
  - S: {ir[31:25], ir[11:7]}
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}
  - U: {ir[31:12], 12'b0}
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}
- Operand selection by opcode:
  - OP: op1=rs1, op2=rs2, imm=0.
  - OP_IMM: op1=rs1, op2=I-imm. For funct3 SLL/SRL-SRA, op2 is zero-extended ir[24:20].
  - LOAD: op1=rs1, op2=I-imm.
  - STORE: op1=rs1, op2=rs2, imm=S-imm.
  - BRANCH: op1=rs1, op2=rs2, imm=B-imm.
  - LUI: op1=0, op2=U-imm.
  - AUIPC: op1=pc, op2=U-imm.
  - JAL: op1=pc, op2=J-imm.
  - JALR: op1=rs1, op2=I-imm.
- Illegal encodings:
  - Any other opcode, ir==0, or ir[1:0]!=2'b11 sets out_illegal=1 with op1=op2=imm=0.
  - With RF_ADDR_W=4, a set bit 4 in rs1, rs2 or rd is also illegal.
- Register x0 reads as 0 regardless of rs*_data.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Full throughput: back-to-back accepts while out_ready=1.
- Reset value of every output register is 0: out_valid, op1/op2/imm, pc, rd, fields, illegal. in_ready is 1 after reset.
- Reset mid-stall drops the held instruction immediately.
- While out_valid && !out_ready, all outputs hold stable, except for the stall refresh below.
- Stall refresh: if wb_en and wb_addr!=0 match the held instruction's rs1 (respectively rs2), and that operand was sourced from the register file, the held op1 (respectively op2) is replaced by wb_data at that edge. Immediate and PC operands are never refreshed.

## Configuration
- DECODE_BYPASS_EN defined:
  - At capture, a register operand whose index equals wb_addr (wb_en=1, wb_addr!=0) takes wb_data instead of rs*_data.
  - The stall refresh is enabled.
- Undefined:
  - Operands come from rs*_data only.
  - The stall refresh logic is absent; the register file must provide write-before-read.
- Handshake, immediates and the illegal flag are identical in both builds.

## Test plan
- Reset, then present ADDI x1,x2,-5 (0xFFB10093) with rs1_data=10 -> next cycle out_valid=1, op1=10, op2=0xFFFFFFFB, rd=1, illegal=0.
- BEQ with encoded offset -8, pc=0x100 -> imm=0xFFFFFFF8, out_pc=0x100, op1/op2 = rs1/rs2 data.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no second accept. Release -> next instruction captured the following cycle.
- Flush asserted together with in_valid while out_valid=1 -> out_valid=0 next edge, incoming instruction lost.
- Bypass build: accept ADD x3,x1,x2 while wb_en=1, wb_addr=1, wb_data=0x55 and rs1_data=0 -> op1=0x55. Then stall and write x2=0x77 -> held op2 becomes 0x77. Non-bypass build: op1=0, op2 unchanged.
- in_ir=0x00000000 and opcode 0x7F -> illegal=1, op1=op2=imm=0. RF_ADDR_W=4 with rd=x16 -> illegal=1.
